// File: rtl/ysyx_25020037_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, one transaction outstanding.
// Define YSYX_25020037_ARB_RR_EN for round-robin tie-break; default is fixed LSU priority.
module ysyx_25020037_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // Last RESP cycle before forced completion: cnt runs 0..TIMEOUT_CYC-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        own_lsu;
  logic        grant_lsu;
  logic        grant_any;
  logic        timeout_hit;

`ifdef YSYX_25020037_ARB_RR_EN
  logic last_lsu;
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu);
`else
  assign grant_lsu = lsu_req_valid;
`endif

  assign grant_any     = ifu_req_valid | lsu_req_valid;
  assign ifu_req_ready = (state == IDLE) & ifu_req_valid & ~grant_lsu;
  assign lsu_req_ready = (state == IDLE) & grant_lsu;
  assign busy          = (state != IDLE);
  assign timeout_hit   = (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      own_lsu        <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= 32'd0;
      mem_we         <= 1'b0;
      mem_wdata      <= 32'd0;
      mem_wstrb      <= 4'd0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= 32'd0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= 32'd0;
      lsu_resp_err   <= 1'b0;
`ifdef YSYX_25020037_ARB_RR_EN
      last_lsu       <= 1'b0;
`endif
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            own_lsu       <= grant_lsu;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_25020037_ARB_RR_EN
            last_lsu      <= grant_lsu;
`endif
            if (grant_lsu) begin
              mem_addr  <= lsu_addr;
              mem_we    <= lsu_we;
              mem_wdata <= lsu_wdata;
              mem_wstrb <= lsu_wstrb;
            end else begin
              mem_addr  <= ifu_addr;
              mem_we    <= 1'b0;
              mem_wdata <= 32'd0;
              mem_wstrb <= 4'd0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= 16'd0;
            state         <= RESP;
          end
        end
        RESP: begin
          // A real response wins even on the last cycle before timeout.
          if (mem_resp_valid || timeout_hit) begin
            state <= IDLE;
            if (own_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= mem_resp_valid ? mem_rdata : 32'd0;
              lsu_resp_err   <= mem_resp_valid ? mem_resp_err : 1'b1;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= mem_resp_valid ? mem_rdata : 32'd0;
              ifu_resp_err   <= mem_resp_valid ? mem_resp_err : 1'b1;
            end
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_mem_arbiter.sv
// Randomized bench for ysyx_25020037_mem_arbiter against a transaction-level model.
// Honours YSYX_25020037_ARB_RR_EN the same way as the design.
module tb_ysyx_25020037_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_rdata;
  logic        busy;

  ysyx_25020037_mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: who was granted last, and what each requester last saw.
  logic        last_lsu_m;
  logic [31:0] exp_ifu_rdata, exp_lsu_rdata;
  logic        exp_ifu_err, exp_lsu_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_resp_hold();
    check_val("ifu_rdata_hold", ifu_rdata, exp_ifu_rdata);
    check_val("ifu_err_hold", ifu_resp_err, exp_ifu_err);
    check_val("lsu_rdata_hold", lsu_rdata, exp_lsu_rdata);
    check_val("lsu_err_hold", lsu_resp_err, exp_lsu_err);
  endtask

  // One full transaction: request, stall cycles in REQ, response delay, idle gap.
  task automatic run_txn(input logic iv, input logic lv, input int stall, input int dly,
                         input int idle, input logic hold);
    logic        own_l, we, er;
    logic [31:0] a_i, a_l, wd, rd, exp_rd;
    logic [3:0]  ws;
    int          done_edge;
    a_i = $urandom; a_l = $urandom; wd = $urandom; rd = $urandom;
    we = 1'($urandom_range(0, 1)); er = 1'($urandom_range(0, 1));
    ws = 4'($urandom_range(0, 15));
    ifu_req_valid = iv; ifu_addr = a_i;
    lsu_req_valid = lv; lsu_addr = a_l; lsu_we = we; lsu_wdata = wd; lsu_wstrb = ws;
    mem_resp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
`ifdef YSYX_25020037_ARB_RR_EN
    own_l = lv && (!iv || !last_lsu_m);
`else
    own_l = lv;
`endif
    last_lsu_m = own_l;
    #1;
    check_val("busy_idle", busy, 0);
    check_val("ifu_req_ready", ifu_req_ready, iv && !own_l);
    check_val("lsu_req_ready", lsu_req_ready, own_l);
    @(posedge clk); #1;
    if (!hold) begin ifu_req_valid = 0; lsu_req_valid = 0; end
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
    lsu_we = ~we; lsu_wstrb = ~ws;
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready  = (i == stall);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_rdata      = $urandom;
      mem_resp_err   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("mem_req_valid", mem_req_valid, 1);
      check_val("mem_addr", mem_addr, own_l ? a_l : a_i);
      check_val("mem_we", mem_we, own_l ? we : 1'b0);
      check_val("mem_wdata", mem_wdata, own_l ? wd : 32'd0);
      check_val("mem_wstrb", mem_wstrb, own_l ? ws : 4'd0);
      check_val("ready_in_req", {ifu_req_ready, lsu_req_ready}, 0);
      check_val("resp_in_req", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(posedge clk); #1;
    end
    mem_req_ready = 0; ifu_req_valid = 0; lsu_req_valid = 0;
    done_edge = (dly < TO) ? dly + 1 : TO;
    for (int j = 1; j <= done_edge; j++) begin
      mem_resp_valid = (j == dly + 1);
      mem_rdata      = (j == dly + 1) ? rd : $urandom;
      mem_resp_err   = (j == dly + 1) ? er : 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("mem_req_valid_resp", mem_req_valid, 0);
      check_val("resp_early", {ifu_resp_valid, lsu_resp_valid}, 0);
      check_val("busy_resp", busy, 1);
      @(posedge clk); #1;
    end
    mem_resp_valid = 0;
    exp_rd = (dly < TO) ? rd : 32'd0;
    if (own_l) begin
      exp_lsu_rdata = exp_rd; exp_lsu_err = (dly < TO) ? er : 1'b1;
    end else begin
      exp_ifu_rdata = exp_rd; exp_ifu_err = (dly < TO) ? er : 1'b1;
    end
    @(negedge clk);
    check_val("ifu_resp_valid", ifu_resp_valid, !own_l);
    check_val("lsu_resp_valid", lsu_resp_valid, own_l);
    check_val("busy_done", busy, 0);
    check_resp_hold();
    for (int k = 0; k < idle; k++) begin
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom; mem_resp_err = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("resp_idle", {ifu_resp_valid, lsu_resp_valid}, 0);
      check_val("busy_idle_gap", busy, 0);
      check_resp_hold();
    end
    mem_resp_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pat;
    rst_n = 0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_we = 0; lsu_wdata = 0; lsu_wstrb = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
    last_lsu_m = 0;
    exp_ifu_rdata = 0; exp_lsu_rdata = 0; exp_ifu_err = 0; exp_lsu_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_mem_req_valid", mem_req_valid, 0);
    check_val("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
    check_resp_hold();
    @(negedge clk);
    rst_n = 1;

    run_txn(1, 0, 0, 0, 1, 0);
    run_txn(0, 1, 4, 0, 1, 0);
    for (int t = 0; t < 4; t++) run_txn(1, 1, 0, 0, 0, 1);
    run_txn(0, 1, 0, TO - 1, 1, 0);
    run_txn(1, 0, 0, TO, 3, 0);
    run_txn(1, 1, 1, TO + 3, 1, 0);

    for (int t = 0; t < 200; t++) begin
      pat = $urandom_range(1, 3);
      run_txn(pat[0], pat[1], $urandom_range(0, 3), $urandom_range(0, TO + 2),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a response wait.
    lsu_req_valid = 1; lsu_addr = $urandom; lsu_we = 0;
    @(posedge clk); #1;
    lsu_req_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    @(posedge clk); #1;
    check_val("busy_before_rst", busy, 1);
    rst_n = 0;
    #1;
    last_lsu_m = 0;
    exp_ifu_rdata = 0; exp_lsu_rdata = 0; exp_ifu_err = 0; exp_lsu_err = 0;
    check_val("arst_busy", busy, 0);
    check_val("arst_mem_req_valid", mem_req_valid, 0);
    check_val("arst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
    check_resp_hold();
    @(negedge clk);
    rst_n = 1;
    mem_resp_valid = 1; mem_rdata = $urandom; mem_resp_err = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("post_rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      check_val("post_rst_busy", busy, 0);
      check_resp_hold();
    end
    mem_resp_valid = 0;
    run_txn(1, 1, 0, 0, 1, 0);
    run_txn(1, 1, 2, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_mem_arbiter.md
YSYX_25020037_MEM_ARBITER -- requirements
Module: ysyx_25020037_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, response-wait cycles before forced error completion (range 1..65535).
REQ-002 clk  in  1  core clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ifu_req_valid  in  1  fetch request; ifu_req_ready  out  1  fetch request accepted.
REQ-005 ifu_addr  in  32  fetch address (read only).
REQ-006 ifu_resp_valid  out  1  one-cycle fetch completion; ifu_rdata  out  32; ifu_resp_err  out  1.
REQ-007 lsu_req_valid  in  1; lsu_req_ready  out  1; lsu_addr  in  32; lsu_we  in  1  1=store.
REQ-008 lsu_wdata  in  32; lsu_wstrb  in  4  byte enables, stores only.
REQ-009 lsu_resp_valid  out  1; lsu_rdata  out  32; lsu_resp_err  out  1.
REQ-010 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  32; mem_we  out  1; mem_wdata  out  32; mem_wstrb  out  4.
REQ-011 mem_resp_valid  in  1; mem_rdata  in  32; mem_resp_err  in  1.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 FSM states IDLE, REQ, RESP; one outstanding transaction total.
REQ-014 IDLE: if any *_req_valid, select winner combinationally; winner's *_req_ready=1 same cycle, loser's ready=0; capture addr/we/wdata/wstrb and owner; next state REQ.
REQ-015 IFU captures force we=0, wstrb=4'b0000, wdata=0.
REQ-016 *_req_ready SHALL be 0 in REQ and RESP.
REQ-017 REQ: mem_req_valid=1 with captured fields stable; on mem_req_ready=1 go RESP and clear timeout counter; otherwise hold (no timeout in REQ).
REQ-018 RESP: counter increments per cycle; on mem_resp_valid, register mem_rdata/mem_resp_err to owner outputs; owner *_resp_valid=1 exactly next cycle; state IDLE that same next cycle.
REQ-019 RESP timeout: counter reaching TIMEOUT_CYC without mem_resp_valid completes to owner with rdata=0, err=1; go IDLE.
REQ-020 mem_resp_valid in IDLE or REQ (stray/late) SHALL be ignored, no output change.
REQ-021 Non-owner *_resp_valid SHALL stay 0; rdata/err outputs hold last value when resp_valid=0.
REQ-022 New request may be granted in the IDLE cycle where previous resp_valid is asserted (back-to-back: one transaction per 3 cycles minimum with zero-wait memory).
REQ-023 Requester deasserting req_valid before grant: no effect, no state change.
REQ-024 Counter width 16 bits, saturating, never wraps.

Reset
REQ-025 rst_n low asynchronously: state IDLE, all *_resp_valid=0, mem_req_valid=0, rdata outputs 0, err 0, counter 0, last-grant=IFU.
REQ-026 Reset mid-transaction abandons it; no response issued after release; first post-reset memory response ignored per REQ-020.

Configuration
REQ-027 Macro YSYX_25020037_ARB_RR_EN defined: round-robin; on simultaneous requests grant requester not granted last; last-grant updates on every grant.
REQ-028 Macro undefined: fixed priority, LSU always wins ties; last-grant register absent.
REQ-029 Single requester: granted immediately in both configurations.

Verification
REQ-030 Single IFU read 0x8000_0000, memory ready=1, resp next cycle rdata=0xDEADBEEF -> ifu_resp_valid 1 cycle with 0xDEADBEEF, err=0, lsu_resp_valid=0.
REQ-031 LSU store addr 0x8000_0010 wdata 0x12345678 wstrb 0x3 -> mem_we=1, fields held stable across 4 cycles of mem_req_ready=0, lsu_resp_valid after response.
REQ-032 Both request in IDLE for 4 transactions: RR_EN -> grants LSU,IFU,LSU,IFU; without -> LSU x4 while LSU holds valid.
REQ-033 TIMEOUT_CYC=8, memory never responds -> owner resp_valid with err=1, rdata=0 on 9th cycle after entering RESP; late mem_resp_valid then ignored.
REQ-034 Assert rst_n=0 during RESP -> outputs reset immediately (no clock); memory response after release produces no *_resp_valid.
